mask_stream_checker: RTL

MASK_STREAM_CHECKER -- requirements
Module: mask_stream_checker

---
 rtl/mask_stream_checker.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mask_stream_checker.sv
// Mask stream checker: locks onto the Galois LFSR mask sequence, then flywheels on its
// own prediction while counting mismatches in a saturating error counter.
module mask_stream_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOST_CNT = 2,
  parameter int ERR_W    = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [31:0]      data_i,
  output logic             ready_o,
  output logic             locked_o,
  output logic [1:0]       state_o,
  output logic [31:0]      expected_o,
  output logic             mismatch_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  // Handshake: a word is consumed on a rising edge where valid_i && ready_o and clear_i is low;
  // valid_i carries no obligation to stay asserted, and ready_o depends only on registered state.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_C = LOCK_CNT[3:0];
  localparam logic [3:0] LOST_C = LOST_CNT[3:0];

  function automatic logic [31:0] step(input logic [31:0] x);
    step = {x[0], x[31:1]} ^ (x[0] ? 32'h0040_0006 : 32'h0000_0000);
  endfunction

  state_t             state_q, state_d;
  logic [3:0]         match_q, match_d;
  logic [3:0]         miss_q, miss_d;
  logic [31:0]        exp_q, exp_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               mismatch_q, mismatch_d;
  logic               ready_q, ready_d;
  logic               locked_q;
  logic               accept;

  assign accept = valid_i && ready_q;

  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    miss_d     = miss_q;
    exp_d      = exp_q;
    err_d      = err_q;
    mismatch_d = 1'b0;
    ready_d    = 1'b1;
    if (clear_i) begin
      state_d = ST_IDLE;
      match_d = '0;
      miss_d  = '0;
      exp_d   = '0;
      err_d   = '0;
      ready_d = 1'b0;
    end else if (accept) begin
      case (state_q)
        ST_IDLE, ST_LOST: begin
          // Zero is the LFSR lock-up value and can never seed a valid sequence.
          if (data_i != 32'h0) begin
            state_d = ST_SYNC;
            exp_d   = step(data_i);
            match_d = '0;
            miss_d  = '0;
          end
        end
        ST_SYNC: begin
          if (data_i == exp_q) begin
            match_d = match_q + 4'd1;
            exp_d   = step(data_i);
            if (match_q + 4'd1 == LOCK_C) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else if (data_i != 32'h0) begin
            exp_d   = step(data_i);
            match_d = '0;
          end else begin
            state_d = ST_IDLE;
            match_d = '0;
          end
        end
        default: begin
          // LOCKED: the prediction advances regardless of what arrived.
          exp_d = step(exp_q);
          if (data_i == exp_q) begin
            miss_d = '0;
          end else begin
            mismatch_d = 1'b1;
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            miss_d = miss_q + 4'd1;
            if (miss_q + 4'd1 == LOST_C) state_d = ST_LOST;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      match_q    <= '0;
      miss_q     <= '0;
      exp_q      <= '0;
      err_q      <= '0;
      mismatch_q <= 1'b0;
      ready_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      exp_q      <= exp_d;
      err_q      <= err_d;
      mismatch_q <= mismatch_d;
      ready_q    <= ready_d;
      locked_q   <= (state_d == ST_LOCKED);
    end
  end

  assign ready_o    = ready_q;
  assign locked_o   = locked_q;
  assign state_o    = state_q;
  assign expected_o = exp_q;
  assign mismatch_o = mismatch_q;
  assign err_cnt_o  = err_q;

endmodule
